mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access stage controller between the EX/MEM latch and the MEM/WB latch.
- Issues data-cache read/write requests for LW/SW/LL/SC and holds the request until dhit.
- Raises mem_stall to freeze the pipeline while a request is pending.
- Presents load data (dload) to the MEM/WB latch and keeps the LL/SC link register.

Parameters:
- WORD_W, 32, data and address width (matches cpu_types_pkg word_t).
- LLSC_EN, 1, 1 = link register and SC conditional store implemented; 0 = SC behaves as SW and returns 1.

Ports:
- CLK  in  1  system clock.
- nRST  in  1  asynchronous active-low reset.
- opcode_MEM  in  6  opcode from the EX/MEM latch (opcode_t).
- halt_MEM  in  1  halt flag; suppresses all requests when high.
- aluout_MEM  in  WORD_W  effective address.
- busB_MEM  in  WORD_W  store data.
- pipe_en  in  1  global latch enable from the hazard unit; high means the MEM instruction advances this edge.
- dhit  in  1  cache completed the current request this cycle.
- dmemload  in  WORD_W  cache read data, valid when dhit.
- ccinv  in  1  coherence invalidate strobe.
- ccinvaddr  in  WORD_W  invalidated address.
- dmemREN  out  1  cache read request.
- dmemWEN  out  1  cache write request.
- dmemaddr  out  WORD_W  request address (= aluout_MEM).
- dmemstore  out  WORD_W  store data (= busB_MEM).
- dload  out  WORD_W  result to the MEM/WB latch.
- mem_stall  out  1  pipeline freeze request.
- link_valid  out  1  debug view of the link register.

Behaviour:
- Reset: FSM=IDLE, link_valid=0, link_addr=0, dload_q=0. All outputs low or zero.
- Address compares use bits [WORD_W-1:2] only.
- Request decode:
  - is_mem = opcode in {LW, LL, SW, SC} and !halt_MEM.
  - sc_fail = (opcode==SC) and LLSC_EN and !(link_valid and link_addr==aluout_MEM).
  - req = is_mem and !sc_fail.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - If req: drive dmemREN (LW/LL) or dmemWEN (SW/SC) combinationally in the same cycle.
  - req and dhit and pipe_en -> stay IDLE; the instruction retires.
  - req and dhit and !pipe_en -> DONE; capture result into dload_q.
  - req and !dhit -> WAIT.
- WAIT:
  - Keep driving the request with address and data stable.
  - dhit -> IDLE if pipe_en, else DONE with capture.
- DONE:
  - REN=WEN=0, so there is no repeated store.
  - dload=dload_q, mem_stall=0.
  - pipe_en -> IDLE.
- mem_stall = (state IDLE or WAIT) and req and !dhit. mem_stall is zero in DONE.
- dload:
  - LW/LL: dmemload when dhit, else dload_q in DONE.
  - SC success: 1.
  - SC fail: 0 with zero latency, no request, no stall.
  - Non-memory ops: 0.
- Link register (LLSC_EN=1):
  - LL completing on dhit: link_valid=1, link_addr=aluout_MEM.
  - SC completing, or failing when pipe_en: link_valid=0.
  - SW completing to link_addr: link_valid=0.
  - ccinv with ccinvaddr==link_addr: link_valid=0. This has priority over a same-cycle LL set only if the addresses match.
- ccinv arriving while an SC is in WAIT to the same address: the SC still completes as a success. The link was checked at issue.
- halt_MEM high in WAIT: not possible, since the latch is frozen. Halt is only evaluated in IDLE.
- Asynchronous reset mid-WAIT: return to IDLE and drop the request immediately. The cache tolerates an abandoned request.
- Latency: 0 wait cycles on hit-same-cycle, otherwise N cycles until dhit.

Decomposition:
- cpu_types_pkg (existing): opcode_t, word_t, the LW/SW/LL/SC constants.
- New enum memstate_t {IDLE, WAIT, DONE} in cpu_types_pkg.
- One natural sub-module: llsc_link, which holds link_valid/link_addr with set, clear and invalidate inputs.
- Group the ports in a new mem_stage_if with modports ms (block) and tb.

Test Plan:
- LW addr 0x100, dhit after 3 cycles, dmemload 0xDEADBEEF, pipe_en=1 on hit -> REN high 4 cycles, mem_stall high 3 cycles, dload=0xDEADBEEF on the hit cycle.
- SW addr 0x200 data 0x12345678, dhit same cycle, pipe_en=0 for 2 cycles -> WEN for exactly 1 cycle, state DONE, no second WEN, mem_stall=0.
- LL 0x300, then SC 0x300 data 7 -> link_valid=1 after LL, SC issues WEN, dload=1, link_valid=0.
- LL 0x300, ccinv ccinvaddr=0x300, then SC 0x300 -> no WEN, dload=0, mem_stall=0.
- LL 0x300, SW 0x304 (no clear), SW 0x302 (same word, clear), then SC 0x300 -> SC fails with dload=0.
- nRST low during WAIT -> REN drops asynchronously, link_valid=0; after release the next LW completes normally.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, opcodes seen by the memory stage, and the
// memory-stage controller states.
package cpu_types_pkg;

  localparam int WORD_WIDTH = 32;

  typedef logic [WORD_WIDTH-1:0] word_t;

  typedef enum logic [5:0] {
    RTYPE = 6'b000000,
    ADDI  = 6'b001000,
    LW    = 6'b100011,
    SW    = 6'b101011,
    LL    = 6'b110000,
    SC    = 6'b111000
  } opcode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } memstate_t;

endpackage

// File: rtl/mem_stage_if.sv
// Port bundle for the memory-access stage: ms is the block side, tb the
// pipeline/cache side driving it.
interface mem_stage_if
  import cpu_types_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input logic CLK,
  input logic nRST
);

  opcode_t           opcode_MEM;
  logic              halt_MEM;
  logic [WORD_W-1:0] aluout_MEM;
  logic [WORD_W-1:0] busB_MEM;
  logic              pipe_en;
  logic              dhit;
  logic [WORD_W-1:0] dmemload;
  logic              ccinv;
  logic [WORD_W-1:0] ccinvaddr;
  logic              dmemREN;
  logic              dmemWEN;
  logic [WORD_W-1:0] dmemaddr;
  logic [WORD_W-1:0] dmemstore;
  logic [WORD_W-1:0] dload;
  logic              mem_stall;
  logic              link_valid;

  modport ms (
    input  CLK, nRST, opcode_MEM, halt_MEM, aluout_MEM, busB_MEM, pipe_en,
           dhit, dmemload, ccinv, ccinvaddr,
    output dmemREN, dmemWEN, dmemaddr, dmemstore, dload, mem_stall, link_valid
  );

  modport tb (
    input  CLK, nRST, dmemREN, dmemWEN, dmemaddr, dmemstore, dload, mem_stall,
           link_valid,
    output opcode_MEM, halt_MEM, aluout_MEM, busB_MEM, pipe_en, dhit, dmemload,
           ccinv, ccinvaddr
  );

endinterface

// File: rtl/llsc_link.sv
// LL/SC link register: set by a completing LL, cleared by SC/aliasing SW, and
// invalidated by coherence traffic to the linked word.
module llsc_link #(
  parameter int WORD_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              set_i,
  input  logic [WORD_W-1:0] set_addr_i,
  input  logic              clr_i,
  input  logic              inv_i,
  input  logic [WORD_W-1:0] inv_addr_i,
  output logic              valid_o,
  output logic [WORD_W-1:0] addr_o
);

  logic              valid_q, valid_d;
  logic [WORD_W-1:0] addr_q, addr_d;
  logic              inv_hits_set, inv_hits_link;

  // Word-granular compares: byte offset bits do not distinguish a link.
  assign inv_hits_set  = inv_i && (inv_addr_i[WORD_W-1:2] == set_addr_i[WORD_W-1:2]);
  assign inv_hits_link = inv_i && (inv_addr_i[WORD_W-1:2] == addr_q[WORD_W-1:2]);

  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    if (set_i) begin
      addr_d  = set_addr_i;
      valid_d = !inv_hits_set;
    end else if (clr_i || inv_hits_link) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
    end
  end

  assign valid_o = valid_q;
  assign addr_o  = addr_q;

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage controller: issues data-cache requests for LW/SW/LL/SC,
// stalls until dhit, and hands the load/SC result to the MEM/WB latch.
module mem_stage
  import cpu_types_pkg::*;
#(
  parameter int WORD_W  = 32,
  parameter bit LLSC_EN = 1'b1
) (
  input  logic              CLK,
  input  logic              nRST,
  input  opcode_t           opcode_MEM,
  input  logic              halt_MEM,
  input  logic [WORD_W-1:0] aluout_MEM,
  input  logic [WORD_W-1:0] busB_MEM,
  input  logic              pipe_en,
  input  logic              dhit,
  input  logic [WORD_W-1:0] dmemload,
  input  logic              ccinv,
  input  logic [WORD_W-1:0] ccinvaddr,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [WORD_W-1:0] dmemaddr,
  output logic [WORD_W-1:0] dmemstore,
  output logic [WORD_W-1:0] dload,
  output logic              mem_stall,
  output logic              link_valid
);

  memstate_t         state_q;
  logic [WORD_W-1:0] dload_q;
  logic [WORD_W-1:0] link_addr;
  logic [WORD_W-1:0] result;
  logic is_read, is_write, is_ll, is_sw, is_sc;
  logic is_mem, link_hit, sc_fail, req, issue, complete;
  logic link_set, link_clr;

  assign is_ll    = (opcode_MEM == LL);
  assign is_sw    = (opcode_MEM == SW);
  assign is_sc    = (opcode_MEM == SC);
  assign is_read  = (opcode_MEM == LW) || is_ll;
  assign is_write = is_sw || is_sc;
  assign is_mem   = (is_read || is_write) && !halt_MEM;

  assign link_hit = link_valid && (link_addr[WORD_W-1:2] == aluout_MEM[WORD_W-1:2]);
  assign sc_fail  = is_sc && LLSC_EN && !link_hit;
  assign req      = is_mem && !sc_fail;

  // Once in WAIT the request is committed; a later link loss does not cancel it.
  assign issue    = nRST && (((state_q == IDLE) && req) || (state_q == WAIT));
  assign complete = issue && dhit;

  always_comb begin
    result = '0;
    if (is_read) begin
      result = dmemload;
    end else if (is_sc) begin
      result = {{(WORD_W-1){1'b0}}, 1'b1};
    end
  end

  assign dmemREN   = issue && is_read;
  assign dmemWEN   = issue && is_write;
  assign dmemaddr  = aluout_MEM;
  assign dmemstore = busB_MEM;
  assign mem_stall = issue && !dhit;
  assign dload     = (state_q == DONE) ? dload_q : (complete ? result : '0);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      dload_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req && dhit && !pipe_en) begin
            state_q <= DONE;
            dload_q <= result;
          end else if (req && !dhit) begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (dhit) begin
            if (pipe_en) begin
              state_q <= IDLE;
            end else begin
              state_q <= DONE;
              dload_q <= result;
            end
          end
        end
        DONE: begin
          if (pipe_en) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign link_set = complete && is_ll;
  assign link_clr = (complete && is_sc)
                 || ((state_q == IDLE) && is_mem && sc_fail && pipe_en)
                 || (complete && is_sw && (link_addr[WORD_W-1:2] == aluout_MEM[WORD_W-1:2]));

  generate
    if (LLSC_EN) begin : g_link
      llsc_link #(.WORD_W(WORD_W)) u_link (
        .clk_i      (CLK),
        .rst_ni     (nRST),
        .set_i      (link_set),
        .set_addr_i (aluout_MEM),
        .clr_i      (link_clr),
        .inv_i      (ccinv),
        .inv_addr_i (ccinvaddr),
        .valid_o    (link_valid),
        .addr_o     (link_addr)
      );
    end else begin : g_no_link
      assign link_valid = 1'b0;
      assign link_addr  = '0;
    end
  endgenerate

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: hand-computed vectors covering loads, stores,
// DONE capture, LL/SC link behaviour, halt and asynchronous reset mid-request.
module tb_mem_stage;
  import cpu_types_pkg::*;

  logic        CLK = 1'b0;
  logic        nRST;
  opcode_t     opcode_MEM;
  logic        halt_MEM;
  logic [31:0] aluout_MEM, busB_MEM;
  logic        pipe_en, dhit;
  logic [31:0] dmemload;
  logic        ccinv;
  logic [31:0] ccinvaddr;
  logic        dmemREN, dmemWEN, mem_stall, link_valid;
  logic [31:0] dmemaddr, dmemstore, dload;

  int n_assert = 0;
  int n_fail   = 0;

  mem_stage #(.WORD_W(32), .LLSC_EN(1'b1)) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .opcode_MEM (opcode_MEM),
    .halt_MEM   (halt_MEM),
    .aluout_MEM (aluout_MEM),
    .busB_MEM   (busB_MEM),
    .pipe_en    (pipe_en),
    .dhit       (dhit),
    .dmemload   (dmemload),
    .ccinv      (ccinv),
    .ccinvaddr  (ccinvaddr),
    .dmemREN    (dmemREN),
    .dmemWEN    (dmemWEN),
    .dmemaddr   (dmemaddr),
    .dmemstore  (dmemstore),
    .dload      (dload),
    .mem_stall  (mem_stall),
    .link_valid (link_valid)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input opcode_t op, input logic [31:0] addr, input logic [31:0] data,
                       input logic hit, input logic pe, input logic [31:0] load);
    opcode_MEM = op;
    aluout_MEM = addr;
    busB_MEM   = data;
    dhit       = hit;
    pipe_en    = pipe_en_mux(pe);
    dmemload   = load;
  endtask

  function automatic logic pipe_en_mux(input logic pe);
    return pe;
  endfunction

  task automatic next;
    @(posedge CLK);
    #1;
  endtask

  task automatic nop;
    drive(RTYPE, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0);
  endtask

  initial begin
    nRST = 1'b0; halt_MEM = 1'b0; ccinv = 1'b0; ccinvaddr = '0;
    nop();
    repeat (2) @(negedge CLK);
    chk("rst_ren", dmemREN, 0);
    chk("rst_wen", dmemWEN, 0);
    chk("rst_stall", mem_stall, 0);
    chk("rst_dload", dload, 0);
    chk("rst_link", link_valid, 0);
    #2 nRST = 1'b1;
    next();

    // LW 0x100, hit on the fourth cycle
    for (int i = 0; i < 3; i++) begin
      drive(LW, 32'h100, 32'h0, 1'b0, 1'b0, 32'h0);
      @(negedge CLK);
      $display("LW miss cycle %0d: REN=%0b stall=%0b", i, dmemREN, mem_stall);
      chk("lw_ren_wait", dmemREN, 1);
      chk("lw_stall_wait", mem_stall, 1);
      chk("lw_addr", dmemaddr, 32'h100);
      next();
    end
    drive(LW, 32'h100, 32'h0, 1'b1, 1'b1, 32'hDEADBEEF);
    @(negedge CLK);
    $display("LW hit: REN=%0b stall=%0b dload=%08h", dmemREN, mem_stall, dload);
    chk("lw_ren_hit", dmemREN, 1);
    chk("lw_stall_hit", mem_stall, 0);
    chk("lw_dload_hit", dload, 32'hDEADBEEF);
    next();
    nop();
    @(negedge CLK);
    chk("lw_ren_after", dmemREN, 0);
    chk("lw_stall_after", mem_stall, 0);
    next();

    // SW 0x200 same-cycle hit with pipeline frozen -> DONE, single WEN
    drive(SW, 32'h200, 32'h12345678, 1'b1, 1'b0, 32'h0);
    @(negedge CLK);
    $display("SW hit: WEN=%0b stall=%0b addr=%08h data=%08h", dmemWEN, mem_stall, dmemaddr, dmemstore);
    chk("sw_wen", dmemWEN, 1);
    chk("sw_stall", mem_stall, 0);
    chk("sw_addr", dmemaddr, 32'h200);
    chk("sw_data", dmemstore, 32'h12345678);
    next();
    drive(SW, 32'h200, 32'h12345678, 1'b0, 1'b0, 32'h0);
    @(negedge CLK);
    chk("sw_done_wen1", dmemWEN, 0);
    chk("sw_done_stall1", mem_stall, 0);
    next();
    drive(SW, 32'h200, 32'h12345678, 1'b0, 1'b1, 32'h0);
    @(negedge CLK);
    $display("SW DONE: WEN=%0b stall=%0b", dmemWEN, mem_stall);
    chk("sw_done_wen2", dmemWEN, 0);
    chk("sw_done_stall2", mem_stall, 0);
    next();
    nop();
    next();

    // LW hit while frozen -> result held in DONE
    drive(LW, 32'h110, 32'h0, 1'b1, 1'b0, 32'hCAFEF00D);
    @(negedge CLK);
    chk("lwd_dload_hit", dload, 32'hCAFEF00D);
    next();
    drive(LW, 32'h110, 32'h0, 1'b0, 1'b1, 32'h0);
    @(negedge CLK);
    $display("LW DONE: REN=%0b dload=%08h", dmemREN, dload);
    chk("lwd_ren_done", dmemREN, 0);
    chk("lwd_dload_done", dload, 32'hCAFEF00D);
    next();
    nop();
    @(negedge CLK);
    chk("lwd_ren_idle", dmemREN, 0);
    next();

    // LL 0x300 then SC 0x300 succeeds
    drive(LL, 32'h300, 32'h0, 1'b1, 1'b1, 32'h55);
    @(negedge CLK);
    chk("ll_ren", dmemREN, 1);
    chk("ll_dload", dload, 32'h55);
    next();
    drive(SC, 32'h300, 32'h7, 1'b1, 1'b1, 32'h0);
    @(negedge CLK);
    $display("SC ok: link=%0b WEN=%0b dload=%08h", link_valid, dmemWEN, dload);
    chk("sc_link_before", link_valid, 1);
    chk("sc_wen", dmemWEN, 1);
    chk("sc_dload", dload, 32'h1);
    chk("sc_stall", mem_stall, 0);
    chk("sc_data", dmemstore, 32'h7);
    next();
    nop();
    @(negedge CLK);
    chk("sc_link_after", link_valid, 0);
    next();

    // LL, coherence invalidate, SC fails
    drive(LL, 32'h300, 32'h0, 1'b1, 1'b1, 32'h0);
    next();
    nop(); ccinv = 1'b1; ccinvaddr = 32'h300;
    @(negedge CLK);
    chk("inv_link_before", link_valid, 1);
    next();
    ccinv = 1'b0;
    drive(SC, 32'h300, 32'h7, 1'b0, 1'b1, 32'h0);
    @(negedge CLK);
    $display("SC after inv: link=%0b WEN=%0b dload=%08h stall=%0b", link_valid, dmemWEN, dload, mem_stall);
    chk("inv_link", link_valid, 0);
    chk("inv_sc_wen", dmemWEN, 0);
    chk("inv_sc_dload", dload, 0);
    chk("inv_sc_stall", mem_stall, 0);
    next();
    nop();
    next();

    // LL, SW to another word keeps link, SW to same word clears it
    drive(LL, 32'h300, 32'h0, 1'b1, 1'b1, 32'h0);
    next();
    drive(SW, 32'h304, 32'h1, 1'b1, 1'b1, 32'h0);
    next();
    drive(SW, 32'h302, 32'h2, 1'b1, 1'b1, 32'h0);
    @(negedge CLK);
    chk("swalias_link_kept", link_valid, 1);
    next();
    drive(SC, 32'h300, 32'h7, 1'b0, 1'b1, 32'h0);
    @(negedge CLK);
    $display("SC after aliasing SW: link=%0b WEN=%0b dload=%08h", link_valid, dmemWEN, dload);
    chk("swalias_link_clr", link_valid, 0);
    chk("swalias_sc_wen", dmemWEN, 0);
    chk("swalias_sc_dload", dload, 0);
    next();
    nop();
    next();

    // LL and invalidate in the same cycle: matching address wins, else LL wins
    drive(LL, 32'h600, 32'h0, 1'b1, 1'b1, 32'h0); ccinv = 1'b1; ccinvaddr = 32'h600;
    next();
    ccinv = 1'b0; nop();
    @(negedge CLK);
    chk("llinv_same", link_valid, 0);
    next();
    drive(LL, 32'h600, 32'h0, 1'b1, 1'b1, 32'h0); ccinv = 1'b1; ccinvaddr = 32'h700;
    next();
    ccinv = 1'b0; nop();
    @(negedge CLK);
    $display("LL with other-address inv: link=%0b", link_valid);
    chk("llinv_other", link_valid, 1);
    next();

    // Halt suppresses the request
    drive(LW, 32'h100, 32'h0, 1'b0, 1'b1, 32'h0); halt_MEM = 1'b1;
    @(negedge CLK);
    chk("halt_ren", dmemREN, 0);
    chk("halt_stall", mem_stall, 0);
    next();
    halt_MEM = 1'b0; nop();
    next();

    // Asynchronous reset in WAIT
    drive(LW, 32'h400, 32'h0, 1'b0, 1'b0, 32'h0);
    next();
    @(negedge CLK);
    chk("rstw_ren_wait", dmemREN, 1);
    #1 nRST = 1'b0;
    #1;
    $display("Reset in WAIT: REN=%0b stall=%0b link=%0b", dmemREN, mem_stall, link_valid);
    chk("rstw_ren", dmemREN, 0);
    chk("rstw_stall", mem_stall, 0);
    chk("rstw_link", link_valid, 0);
    #1 nRST = 1'b1;
    drive(LW, 32'h500, 32'h0, 1'b1, 1'b1, 32'h77);
    #1;
    chk("rstw_lw_ren", dmemREN, 1);
    chk("rstw_lw_dload", dload, 32'h77);
    chk("rstw_lw_stall", mem_stall, 0);
    next();
    nop();
    @(negedge CLK);
    chk("rstw_idle_ren", dmemREN, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
